// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - fetch/memory-stage arbiter for one single-port synchronous SRAM
// Per-cycle grant with data priority and a bounded inst starvation window; one access in flight.
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]  owner;
  logic [1:0]  owner_next;
  logic [3:0]  starve_cnt;
  logic        starve_hit;
  logic        grant_inst;
  logic        grant_data;
  logic [31:0] inst_hold;
  logic [31:0] data_hold;

  assign starve_hit = (starve_cnt == LIMIT);

  // Data wins contention until inst has been passed over LIMIT times in a row.
  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (!rst) begin
      grant_data = data_req && !(inst_req && starve_hit);
      grant_inst = inst_req && !grant_data;
    end
  end

  always_comb begin
    owner_next = OWN_NONE;
    if (grant_data) begin
      owner_next = OWN_DATA;
    end else if (grant_inst) begin
      owner_next = OWN_INST;
    end
  end

  always_comb begin
    mem_en    = grant_inst || grant_data;
    mem_wen   = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (grant_data) begin
      mem_wen   = data_wen;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (grant_inst) begin
      mem_addr  = inst_addr;
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  // A reset landing on the return cycle swallows the pending response.
  assign inst_data_ok = !rst && (owner == OWN_INST);
  assign data_data_ok = !rst && (owner == OWN_DATA);

  assign inst_rdata = inst_data_ok ? mem_rdata : inst_hold;
  assign data_rdata = data_data_ok ? mem_rdata : data_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_NONE;
      starve_cnt <= 4'h0;
      inst_hold  <= 32'h0;
      data_hold  <= 32'h0;
    end else begin
      owner <= owner_next;
      if (grant_inst) begin
        starve_cnt <= 4'h0;
      end else if (grant_data && inst_req && (starve_cnt < LIMIT)) begin
        starve_cnt <= starve_cnt + 4'h1;
      end
      if (inst_data_ok) begin
        inst_hold <= mem_rdata;
      end
      if (data_data_ok) begin
        data_hold <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - table-driven bench for sram_arbiter
// Per-cycle vectors checked just before each rising edge, then a sustained contention run.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total;
  int bad;

  sram_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] mrdata;
    logic        e_iaok;
    logic        e_daok;
    logic        e_men;
    logic [3:0]  e_mwen;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        e_idok;
    logic [31:0] e_irdata;
    logic        e_ddok;
    logic [31:0] e_drdata;
  } vec_t;

  localparam int NV = 21;
  vec_t vec [NV];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst        = v.rst;
    inst_req   = v.ireq;
    inst_addr  = v.iaddr;
    data_req   = v.dreq;
    data_wen   = v.dwen;
    data_addr  = v.daddr;
    data_wdata = v.dwdata;
    mem_rdata  = v.mrdata;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //          rst   ireq  iaddr         dreq  dwen  daddr         dwdata        mrdata          iaok  daok  men   mwen  maddr         mwdata        idok  irdata        ddok  drdata
    vec[0]  = '{1'b1, 1'b1, 32'h40,       1'b1, 4'h0, 32'h200,      32'h0,        32'h0,          1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vec[1]  = '{1'b0, 1'b1, 32'h40,       1'b1, 4'h0, 32'h200,      32'h0,        32'h0,          1'b0, 1'b1, 1'b1, 4'h0, 32'h200,      32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vec[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        32'h55,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 32'h55};
    vec[3]  = '{1'b0, 1'b1, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        32'hAA,         1'b1, 1'b0, 1'b1, 4'h0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h55};
    vec[4]  = '{1'b0, 1'b1, 32'h4,        1'b0, 4'h0, 32'h0,        32'h0,        32'h11,         1'b1, 1'b0, 1'b1, 4'h0, 32'h4,        32'h0,        1'b1, 32'h11,       1'b0, 32'h55};
    vec[5]  = '{1'b0, 1'b1, 32'h8,        1'b0, 4'h0, 32'h0,        32'h0,        32'h22,         1'b1, 1'b0, 1'b1, 4'h0, 32'h8,        32'h0,        1'b1, 32'h22,       1'b0, 32'h55};
    vec[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        32'h33,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h33,       1'b0, 32'h55};
    vec[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        32'h99,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 32'h33,       1'b0, 32'h55};
    vec[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 4'hF, 32'h100,      32'hDEADBEEF, 32'h0,          1'b0, 1'b1, 1'b1, 4'hF, 32'h100,      32'hDEADBEEF, 1'b0, 32'h33,       1'b0, 32'h55};
    vec[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 4'h0, 32'h100,      32'h0,        32'h12345678,   1'b0, 1'b1, 1'b1, 4'h0, 32'h100,      32'h0,        1'b0, 32'h33,       1'b1, 32'h12345678};
    vec[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        32'hDEADBEEF,   1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 32'h33,       1'b1, 32'hDEADBEEF};
    vec[11] = '{1'b0, 1'b1, 32'h20,       1'b1, 4'h0, 32'h300,      32'h0,        32'h77,         1'b0, 1'b1, 1'b1, 4'h0, 32'h300,      32'h0,        1'b0, 32'h33,       1'b0, 32'hDEADBEEF};
    vec[12] = '{1'b0, 1'b1, 32'h20,       1'b1, 4'h0, 32'h300,      32'h0,        32'h1,          1'b0, 1'b1, 1'b1, 4'h0, 32'h300,      32'h0,        1'b0, 32'h33,       1'b1, 32'h1};
    vec[13] = '{1'b0, 1'b1, 32'h20,       1'b1, 4'h0, 32'h300,      32'h0,        32'h2,          1'b1, 1'b0, 1'b1, 4'h0, 32'h20,       32'h0,        1'b0, 32'h33,       1'b1, 32'h2};
    vec[14] = '{1'b0, 1'b1, 32'h20,       1'b1, 4'h0, 32'h300,      32'h0,        32'h3,          1'b0, 1'b1, 1'b1, 4'h0, 32'h300,      32'h0,        1'b1, 32'h3,        1'b0, 32'h2};
    vec[15] = '{1'b0, 1'b1, 32'h20,       1'b1, 4'h0, 32'h300,      32'h0,        32'h4,          1'b0, 1'b1, 1'b1, 4'h0, 32'h300,      32'h0,        1'b0, 32'h3,        1'b1, 32'h4};
    vec[16] = '{1'b0, 1'b1, 32'h20,       1'b1, 4'h0, 32'h300,      32'h0,        32'h5,          1'b1, 1'b0, 1'b1, 4'h0, 32'h20,       32'h0,        1'b0, 32'h3,        1'b1, 32'h5};
    vec[17] = '{1'b0, 1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        32'h6,          1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h6,        1'b0, 32'h5};
    vec[18] = '{1'b0, 1'b1, 32'h44,       1'b0, 4'h0, 32'h0,        32'h0,        32'h0,          1'b1, 1'b0, 1'b1, 4'h0, 32'h44,       32'h0,        1'b0, 32'h6,        1'b0, 32'h5};
    vec[19] = '{1'b1, 1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        32'h88,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 32'h6,        1'b0, 32'h5};
    vec[20] = '{1'b0, 1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        32'h99,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0};

    // Pre-roll: reset sampled once so the hold registers are defined for vector 0.
    drive(vec[0]);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i]);
      #4;
      check("inst_addr_ok", i, {31'h0, inst_addr_ok}, {31'h0, vec[i].e_iaok});
      check("data_addr_ok", i, {31'h0, data_addr_ok}, {31'h0, vec[i].e_daok});
      check("mem_en",       i, {31'h0, mem_en},       {31'h0, vec[i].e_men});
      check("mem_wen",      i, {28'h0, mem_wen},      {28'h0, vec[i].e_mwen});
      check("mem_addr",     i, mem_addr,              vec[i].e_maddr);
      check("mem_wdata",    i, mem_wdata,             vec[i].e_mwdata);
      check("inst_data_ok", i, {31'h0, inst_data_ok}, {31'h0, vec[i].e_idok});
      check("inst_rdata",   i, inst_rdata,            vec[i].e_irdata);
      check("data_data_ok", i, {31'h0, data_data_ok}, {31'h0, vec[i].e_ddok});
      check("data_rdata",   i, data_rdata,            vec[i].e_drdata);
    end

    // Sustained contention from a cleared starvation counter: D, D, I repeating.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst        = 1'b0;
      inst_req   = 1'b1;
      inst_addr  = 32'h1000 + 32'(i * 4);
      data_req   = 1'b1;
      data_wen   = 4'h0;
      data_addr  = 32'h2000 + 32'(i * 4);
      data_wdata = 32'h0;
      mem_rdata  = 32'(i);
      #4;
      if ((i % 3) == 2) begin
        check("hold_inst_grant", i, {31'h0, inst_addr_ok}, 32'h1);
        check("hold_inst_addr",  i, mem_addr, 32'h1000 + 32'(i * 4));
      end else begin
        check("hold_data_grant", i, {31'h0, data_addr_ok}, 32'h1);
        check("hold_data_addr",  i, mem_addr, 32'h2000 + 32'(i * 4));
      end
      check("hold_ok_overlap", i, {31'h0, inst_data_ok && data_data_ok}, 32'h0);
      if (i > 0) begin
        check("hold_inst_ok", i, {31'h0, inst_data_ok}, {31'h0, ((i - 1) % 3) == 2});
        check("hold_data_ok", i, {31'h0, data_data_ok}, {31'h0, ((i - 1) % 3) != 2});
      end
    end

    @(negedge clk);
    inst_req = 1'b0;
    data_req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single-port synchronous SRAM between the fetch stage and the memory stage of the CPU. Each side uses its own sram-like request channel (req / addr_ok / data_ok). The block arbitrates per cycle and issues at most one access per cycle to the SRAM. It tracks the single in-flight access and routes its return data and data_ok back to the owner. It sits between the datapath's fetch/memory interfaces and the SRAM port in the CPU top level.

## Interface
- STARVE_LIMIT, 2: consecutive data grants while inst_req is pending, after which inst wins one cycle (range 1–15).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request valid; held until inst_addr_ok.
- inst_addr  in  32  fetch address (physical, word-aligned).
- inst_addr_ok  out  1  fetch request accepted this cycle (combinational).
- inst_data_ok  out  1  fetch return valid this cycle.
- inst_rdata  out  32  fetch return data.
- data_req  in  1  memory-stage request valid; held until data_addr_ok.
- data_wen  in  4  byte write enables; 0 = read.
- data_addr  in  32  data address (physical).
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request accepted this cycle (combinational).
- data_data_ok  out  1  data access complete this cycle (reads and writes).
- data_rdata  out  32  load return data.
- mem_en  out  1  SRAM access issued this cycle.
- mem_wen  out  4  SRAM byte write enables.
- mem_addr  out  32  SRAM address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid the cycle after issue.

## Operation
- Owner FSM, 2-bit register, states NONE / INST / DATA. It records who owns the access issued in the previous cycle.
  - Next state = DATA if data granted this cycle.
  - Next state = INST if inst granted this cycle.
  - Next state = NONE otherwise.
  - The transition does not depend on the current state: one-cycle SRAM latency permits issue every cycle.
- Grant rule, evaluated each cycle:
  - Only data_req asserted: grant data.
  - Only inst_req asserted: grant inst.
  - Both asserted: grant data, unless starve_cnt == STARVE_LIMIT; then grant inst.
- starve_cnt, 4-bit:
  - Cleared on any inst grant.
  - Incremented, saturating at STARVE_LIMIT, on a data grant while inst_req = 1.
  - Unchanged otherwise.
- Issue, combinational:
  - mem_en = 1 when any grant is made.
  - Data grant: mem_addr = data_addr, mem_wen = data_wen, mem_wdata = data_wdata.
  - Inst grant: mem_addr = inst_addr, mem_wen = 0, mem_wdata = 0.
  - No grant: mem_addr = 0, mem_wen = 0, mem_wdata = 0.
- inst_addr_ok = inst grant. data_addr_ok = data grant. At most one of the two is high in any cycle.
- Return path:
  - inst_data_ok = (owner == INST). data_data_ok = (owner == DATA).
  - When data_ok is high, the corresponding rdata = mem_rdata, passed through combinationally, and is also captured into a hold register.
  - When data_ok is low, rdata = the hold register value.
  - For a write (data_wen != 0), data_data_ok still pulses. data_rdata then carries mem_rdata and has no defined meaning.
- A requester may present a new request in the cycle after its addr_ok, including the cycle in which its previous data_ok is high.

## Timing
- Reset values:
  - Owner = NONE, starve_cnt = 0.
  - inst_rdata = 0 and data_rdata = 0.
  - inst_data_ok = 0 and data_data_ok = 0 in the cycle after rst is sampled high.
  - Combinational outputs follow their inputs; while rst is high, addr_ok and mem_en are forced to 0.
- Latency: request accepted in cycle N (addr_ok = 1, mem_en = 1); data_ok = 1 in cycle N+1.
- Throughput: one access per cycle overall, including back-to-back accesses from one requester and alternating requesters.
- Simultaneous events:
  - A data_ok for the previous access and a new grant may occur in the same cycle.
  - The new grant's owner only takes effect in the next cycle.
- Reset mid-operation: if rst is high in the cycle after an issue, the pending data_ok is suppressed and the hold registers are cleared.
- Starvation bound: with both requesters continuously asserted, inst is granted at least once every STARVE_LIMIT+1 cycles.

## Test plan
- Reset: assert rst for 2 cycles with both req high → all addr_ok, data_ok and mem_en are 0, rdata = 0; first grant occurs in the cycle rst falls.
- Inst only: inst_req held for 3 cycles at addresses 0x0, 0x4, 0x8; SRAM returns 0x11, 0x22, 0x33 → addr_ok each cycle; inst_data_ok in cycles 2–4 with inst_rdata 0x11, 0x22, 0x33; inst_rdata holds 0x33 afterwards.
- Data store then load: store wen = 0xF, addr 0x100, wdata 0xDEADBEEF, followed by a load of 0x100 → mem_wen = 0xF then 0x0; data_data_ok pulses in cycles 2 and 3; data_rdata = 0xDEADBEEF in cycle 3.
- Contention (STARVE_LIMIT = 2): both req held continuously → grant sequence D, D, I, D, D, I; inst_data_ok and data_data_ok follow one cycle later, never high together.
- Reset mid-flight: inst grant in cycle N, rst high in cycle N+1 → no inst_data_ok; inst_rdata = 0 in N+2.
- Idle: both req low → mem_en = 0, mem_addr = 0, mem_wen = 0; rdata holds its last value.
